prog_target_lut: RTL
====================

// Module: prog_target_lut
// PURPOSE
//   Programmable branch-target / data-address lookup table for the 3BC processor.
//   Successor to the fixed combinational LUT: runtime-writable entries, parametrised depth/width,
//   registered read with valid flag, self-clearing init sequence after reset.
//   Sits between the instruction decoder (read side) and the program loader (write side).
// PARAMETERS
//   IDX_W     4     index width; table depth DEPTH = 2**IDX_W
//   ENT_W     10    stored entry width (two's-complement when SIGN_EXT=1)
//   OUT_W     10    Rd_Data width; must be >= ENT_W
//   SIGN_EXT  1     1: sign-extend entry ENT_W->OUT_W; 0: zero-extend
//   INIT_VAL  1     value written to every entry by the init sequence (truncated to ENT_W)
// PORTS
//   Clk       in   1      clock, all logic on rising edge
//   Reset     in   1      synchronous, active-low reset
//   Busy      out  1      1 while init sequence runs; table inaccessible
//   Wr_En     in   1      write request
//   Wr_Idx    in   IDX_W  write index
//   Wr_Data   in   ENT_W  write data
//   Wr_Ready  out  1      =~Busy; write accepted on edge where Wr_En & Wr_Ready
//   Rd_En     in   1      read request
//   Rd_Idx    in   IDX_W  read index
//   Rd_Data   out  OUT_W  registered read data (extended per SIGN_EXT)
//   Rd_Valid  out  1      1 for exactly the cycle after an accepted read
// BEHAVIOUR
//   - States: INIT, READY. Reset==0 at an edge -> INIT, init counter=0, Rd_Data=0,
//     Rd_Valid=0, Busy=1, Wr_Ready=0. Reset value of every output as listed.
//   - INIT: each edge with Reset==1 writes INIT_VAL to entry[counter], counter++.
//     Edge that writes entry DEPTH-1 -> READY; Busy falls after exactly DEPTH edges.
//   - INIT: Wr_En and Rd_En ignored (no write, Rd_Valid stays 0, Rd_Data holds).
//   - READY: write accepted on edge with Wr_En=1: entry[Wr_Idx] <= Wr_Data.
//   - READY: read accepted on edge with Rd_En=1: Rd_Data <= ext(entry[Rd_Idx]),
//     Rd_Valid <= 1 next cycle; latency 1 cycle. No read: Rd_Valid <= 0, Rd_Data holds.
//   - Same-edge read+write, same index: write-first bypass, Rd_Data = ext(Wr_Data).
//     Different indices: independent, both complete.
//   - Back-to-back reads every cycle supported; Rd_Valid stays high continuously.
//   - Index wrap: none; IDX_W bits address full table, no out-of-range case.
//   - Extension: SIGN_EXT=1 replicates entry bit ENT_W-1 into upper bits; OUT_W==ENT_W passes through.
//   - Reset asserted mid-INIT or mid-READY: next edge returns to INIT, counter=0; all
//     entries rewritten to INIT_VAL (earlier programmed contents lost); pending read dropped.
//   - Table storage has no reset of its own; contents defined only by init sequence.
// TESTING
//   1 Reset low 2 cycles, release -> Busy=1 for 16 edges, falls after 16th; read all 16 -> each Rd_Data=1.
//   2 After init: write idx0=10'h26C (-404), read idx0 -> next cycle Rd_Valid=1, Rd_Data=10'h26C;
//     ENT_W=10,OUT_W=12,SIGN_EXT=1 -> 12'hE6C.
//   3 Same edge Wr_En idx5=10'd77, Rd_En idx5 -> next cycle Rd_Data=77 (bypass);
//     Rd idx6 instead -> Rd_Data=1.
//   4 Wr_En/Rd_En held high during INIT -> no Rd_Valid; after init idx3 still =1.
//   5 Program idx7=10'd300, pulse Reset low mid-stream -> Busy high 16 cycles again; idx7 reads 1.
//   6 Reads idx0..15 on 16 consecutive cycles -> Rd_Valid high 16 cycles, data in index order.

Source files
------------

// File: rtl/prog_target_lut.sv
// prog_target_lut
//   Programmable branch-target / data-address lookup table for the 3BC
//   processor. The program loader writes entries, the instruction decoder
//   reads them. After every reset the table fills itself with INIT_VAL, one
//   entry per clock. While that runs the table is unavailable to both sides.
//
// Ports
//   Clk       in   1      clock; everything changes on the rising edge
//   Reset     in   1      synchronous, active-low reset
//   Busy      out  1      high while the init sequence runs
//   Wr_En     in   1      write request
//   Wr_Idx    in   IDX_W  write index
//   Wr_Data   in   ENT_W  write data
//   Wr_Ready  out  1      inverse of Busy; a write is taken when Wr_En & Wr_Ready
//   Rd_En     in   1      read request
//   Rd_Idx    in   IDX_W  read index
//   Rd_Data   out  OUT_W  registered read data, sign- or zero-extended
//   Rd_Valid  out  1      high for the cycle after each accepted read
module prog_target_lut #(
  parameter int IDX_W    = 4,
  parameter int ENT_W    = 10,
  parameter int OUT_W    = 10,
  parameter int SIGN_EXT = 1,
  parameter int INIT_VAL = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  output logic             Busy,
  input  logic             Wr_En,
  input  logic [IDX_W-1:0] Wr_Idx,
  input  logic [ENT_W-1:0] Wr_Data,
  output logic             Wr_Ready,
  input  logic             Rd_En,
  input  logic [IDX_W-1:0] Rd_Idx,
  output logic [OUT_W-1:0] Rd_Data,
  output logic             Rd_Valid
);

  localparam int               DEPTH    = 2 ** IDX_W;
  localparam logic [ENT_W-1:0] INIT_ENT = ENT_W'(INIT_VAL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] init_cnt;

  logic [ENT_W-1:0] mem [DEPTH];

  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [ENT_W-1:0] mem_wdata;
  logic             rd_acc;
  logic [ENT_W-1:0] rd_ent;

  // Widen a stored entry to the read-port width. A size cast of a signed
  // operand replicates the sign bit, and it is a plain copy when the widths
  // are equal.
  function automatic logic [OUT_W-1:0] extend(input logic [ENT_W-1:0] e);
    if (SIGN_EXT != 0) return OUT_W'($signed(e));
    else               return OUT_W'(e);
  endfunction

  // NOTE: sequential state is updated with non-blocking assignments only.
  // That way every flop samples the values from before the edge, whatever
  // order the simulator evaluates the blocks in.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  // NOTE: every output of this block gets a default before the case. A path
  // that forgets an assignment then cannot infer a latch.
  always_comb begin
    next_state = state;
    Busy       = (state == ST_INIT);
    Wr_Ready   = ~Busy;
    unique case (state)
      ST_INIT:  if (init_cnt == LAST_IDX) next_state = ST_READY;
      ST_READY: next_state = ST_READY;
      default:  next_state = ST_INIT;
    endcase
  end

  // Single write port. During init the counter owns it. Otherwise the loader
  // owns it. An edge with Reset low writes nothing.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = Wr_Idx;
    mem_wdata = Wr_Data;
    if (Reset) begin
      if (state == ST_INIT) begin
        mem_we    = 1'b1;
        mem_widx  = init_cnt;
        mem_wdata = INIT_ENT;
      end else if (Wr_En) begin
        mem_we = 1'b1;
      end
    end
  end

  assign rd_acc = Reset && (state == ST_READY) && Rd_En;

  // Write-first bypass: a read that hits the index being written on the same
  // edge returns the new data, not the old entry.
  assign rd_ent = (Wr_En && (Wr_Idx == Rd_Idx)) ? Wr_Data : mem[Rd_Idx];

  // NOTE: the table array has no reset branch. The init sequence defines its
  // contents, and leaving out the reset lets it map onto RAM.
  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      Rd_Data  <= '0;
      Rd_Valid <= 1'b0;
    end else if (rd_acc) begin
      Rd_Data  <= extend(rd_ent);
      Rd_Valid <= 1'b1;
    end else begin
      Rd_Valid <= 1'b0;
    end
  end

endmodule
